// File: rtl/activation_int8_pkg.sv
// Shared types and defaults for the int8 activation unit.
package activation_int8_pkg;

    localparam int ACT_W               = 8;
    localparam int RELU6_MAX_DEFAULT   = 6;
    localparam int LEAKY_SHIFT_DEFAULT = 2;

    typedef logic signed [ACT_W-1:0] act_t;

    typedef struct packed {
        act_t relu6;
        act_t leaky;
        act_t gelu;
    } act_result_t;

    localparam act_t ACT_ZERO = '0;

endpackage

// File: rtl/activation_int8_core.sv
// Combinational evaluation of ReLU6, LeakyReLU and coarse GELU on one int8 sample.
module activation_int8_core
    import activation_int8_pkg::*;
#(
    parameter int RELU6_MAX   = RELU6_MAX_DEFAULT,
    parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEFAULT
) (
    input  act_t x,
    output act_t y_relu6,
    output act_t y_leaky,
    output act_t y_gelu
);

    localparam act_t RELU6_LIM = act_t'(RELU6_MAX);

    logic x_neg;
    logic x_zero;

    assign x_neg  = x[ACT_W-1];
    assign x_zero = (x == ACT_ZERO);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        y_relu6 = ACT_ZERO;
        y_leaky = x;
        y_gelu  = ACT_ZERO;

        if (x_neg) begin
            // Arithmetic shift on a signed operand floors toward -inf, so -1 stays -1.
            y_leaky = x >>> LEAKY_SHIFT;
        end else begin
            y_relu6 = (x > RELU6_LIM) ? RELU6_LIM : x;
            if (!x_zero) begin
                y_gelu = x >>> 1;
            end
        end
    end

endmodule

// File: rtl/activation_int8_unit.sv
// Registered int8 activation unit: one sample in, three activations out one cycle later.
module activation_int8_unit
    import activation_int8_pkg::*;
#(
    parameter int RELU6_MAX   = RELU6_MAX_DEFAULT,
    parameter int LEAKY_SHIFT = LEAKY_SHIFT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [ACT_W-1:0] x,
    output logic                    out_valid,
    output logic signed [ACT_W-1:0] y_relu6,
    output logic signed [ACT_W-1:0] y_leaky,
    output logic signed [ACT_W-1:0] y_gelu
);

    act_result_t res_d;
    act_result_t res_q;
    logic        valid_q;

    activation_int8_core #(
        .RELU6_MAX   (RELU6_MAX),
        .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_core (
        .x       (x),
        .y_relu6 (res_d.relu6),
        .y_leaky (res_d.leaky),
        .y_gelu  (res_d.gelu)
    );

    // NOTE: the result registers are reset too, since downstream sees y_* = 0 while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep register updates order-independent.
            valid_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign y_relu6   = res_q.relu6;
    assign y_leaky   = res_q.leaky;
    assign y_gelu    = res_q.gelu;

endmodule

// File: tb/tb_activation_int8_unit.sv
// Directed self-checking bench for activation_int8_unit (default and overridden parameters).
module tb_activation_int8_unit;
    import activation_int8_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic in_valid = 1'b0;
    act_t x        = '0;
    logic out_valid;
    act_t y_relu6, y_leaky, y_gelu;

    logic in_valid2 = 1'b0;
    act_t x2        = '0;
    logic out_valid2;
    act_t y2_relu6, y2_leaky, y2_gelu;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    activation_int8_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid),
        .y_relu6   (y_relu6),
        .y_leaky   (y_leaky),
        .y_gelu    (y_gelu)
    );

    activation_int8_unit #(
        .RELU6_MAX   (3),
        .LEAKY_SHIFT (1)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .x         (x2),
        .out_valid (out_valid2),
        .y_relu6   (y2_relu6),
        .y_leaky   (y2_leaky),
        .y_gelu    (y2_gelu)
    );

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Reference model written with plain integer arithmetic.
    function automatic int ref_relu6(input int v, input int lim);
        if (v < 0)   return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    function automatic int ref_leaky(input int v, input int sh);
        int d;
        d = 1 << sh;
        if (v >= 0) return v;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int ref_gelu(input int v);
        if (v <= 0) return 0;
        return v / 2;
    endfunction

    task automatic drive(input logic v, input int xv);
        @(negedge clk);
        in_valid = v;
        x        = act_t'(xv);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int ov, input int r, input int l, input int g);
        check({tag, ".valid"}, int'(out_valid), ov);
        check({tag, ".relu6"}, int'(y_relu6), r);
        check({tag, ".leaky"}, int'(y_leaky), l);
        check({tag, ".gelu"},  int'(y_gelu),  g);
    endtask

    typedef struct {
        int xv;
        int r;
        int l;
        int g;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{7,    6,   7,   3};
        vecs[1] = '{5,    5,   5,   2};
        vecs[2] = '{-2,   0,  -1,   0};
        vecs[3] = '{0,    0,   0,   0};
        vecs[4] = '{127,  6, 127,  63};
        vecs[5] = '{-128, 0, -32,   0};
        vecs[6] = '{-8,   0,  -2,   0};
        vecs[7] = '{8,    6,   8,   4};
        vecs[8] = '{-1,   0,  -1,   0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].xv);
            check_out($sformatf("vec x=%0d", vecs[i].xv), 1, vecs[i].r, vecs[i].l, vecs[i].g);
        end

        // Mid-stream asynchronous reset with in_valid held high
        drive(1'b1, 50);
        check_out("pre_rst", 1, 6, 50, 25);
        #2;
        x   = act_t'(20);
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_out("rst_drop", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_idle.valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check_out("post_rst_first", 1, 6, 20, 10);

        // Full sweep at full throughput against the model
        for (int v = -128; v <= 127; v++) begin
            drive(1'b1, v);
            check_out($sformatf("sweep x=%0d", v), 1,
                      ref_relu6(v, 6), ref_leaky(v, 2), ref_gelu(v));
        end

        // Drop in_valid: results hold the x=127 values
        drive(1'b0, -5);
        check_out("hold1", 0, 6, 127, 63);
        drive(1'b0, -90);
        check_out("hold2", 0, 6, 127, 63);

        // Overridden parameters: RELU6_MAX=3, LEAKY_SHIFT=1
        @(negedge clk);
        in_valid2 = 1'b1;
        x2        = act_t'(5);
        @(posedge clk);
        #1;
        check("p.x5.valid", int'(out_valid2), 1);
        check("p.x5.relu6", int'(y2_relu6), 3);
        check("p.x5.leaky", int'(y2_leaky), 5);
        check("p.x5.gelu",  int'(y2_gelu),  2);
        @(negedge clk);
        x2 = act_t'(-7);
        @(posedge clk);
        #1;
        check("p.xm7.relu6", int'(y2_relu6), 0);
        check("p.xm7.leaky", int'(y2_leaky), -4);
        check("p.xm7.leaky_model", int'(y2_leaky), ref_leaky(-7, 1));
        @(negedge clk);
        x2 = act_t'(-128);
        @(posedge clk);
        #1;
        check("p.xm128.leaky", int'(y2_leaky), -64);
        @(negedge clk);
        in_valid2 = 1'b0;
        @(posedge clk);
        #1;
        check("p.idle.valid", int'(out_valid2), 0);
        check("p.idle.leaky", int'(y2_leaky), -64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
